// File: rtl/ras_predictor.sv
// Return-address stack for the fetch stage: circular storage of the newest DEPTH
// link addresses, with a pointer/count checkpoint for repair after a flush.
module ras_predictor #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [ADDR_W-1:0]     push_addr_i,
  input  logic                  pop_i,
  input  logic                  ckpt_save_i,
  input  logic                  ckpt_restore_i,
  output logic                  top_valid_o,
  output logic [ADDR_W-1:0]     top_addr_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [ADDR_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tos, tos_n, ckpt_tos;
  logic [DEPTH_LOG2:0]   cnt, cnt_n, ckpt_cnt;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  wr_en;
  logic                  ovf_n, udf_n;
  logic                  empty, full;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  // Restore wins over everything; push+pop on a live stack replaces the top in place.
  always_comb begin
    tos_n  = tos;
    cnt_n  = cnt;
    wr_en  = 1'b0;
    wr_idx = tos;
    ovf_n  = 1'b0;
    udf_n  = 1'b0;
    if (ckpt_restore_i) begin
      tos_n = ckpt_tos;
      cnt_n = ckpt_cnt;
    end else if (push_i && pop_i && !empty) begin
      wr_en  = 1'b1;
      wr_idx = tos;
    end else if (push_i) begin
      tos_n  = tos + PTR_ONE;
      wr_en  = 1'b1;
      wr_idx = tos + PTR_ONE;
      if (full) ovf_n = 1'b1;
      else      cnt_n = cnt + CNT_ONE;
    end else if (pop_i) begin
      if (empty) begin
        udf_n = 1'b1;
      end else begin
        tos_n = tos - PTR_ONE;
        cnt_n = cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      tos         <= '1;
      cnt         <= '0;
      ckpt_tos    <= '0;
      ckpt_cnt    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_en) mem[wr_idx] <= push_addr_i;
      tos         <= tos_n;
      cnt         <= cnt_n;
      overflow_o  <= ovf_n;
      underflow_o <= udf_n;
      if (ckpt_save_i && !ckpt_restore_i) begin
        ckpt_tos <= tos_n;
        ckpt_cnt <= cnt_n;
      end
    end
  end

  // top_valid_o qualifies top_addr_o; there is no ready, the consumer samples freely.
  assign top_valid_o = !empty;
  assign top_addr_o  = empty ? '0 : mem[tos];
  assign count_o     = cnt;

endmodule

// File: tb/tb_ras_predictor.sv
// Randomised and directed bench for ras_predictor (DEPTH=4) with a queue scoreboard
// fed by an array-based reference stack.
module tb_ras_predictor;

  localparam int AW = 32;
  localparam int DL = 2;
  localparam int DEPTH = 4;
  localparam int RW = 1 + AW + (DL+1) + 1 + 1;

  logic          clk;
  logic          rst;
  logic          push_i, pop_i, ckpt_save_i, ckpt_restore_i;
  logic [AW-1:0] push_addr_i;
  logic          top_valid_o, overflow_o, underflow_o;
  logic [AW-1:0] top_addr_o;
  logic [DL:0]   count_o;

  ras_predictor #(.ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .push_i(push_i), .push_addr_i(push_addr_i), .pop_i(pop_i),
    .ckpt_save_i(ckpt_save_i), .ckpt_restore_i(ckpt_restore_i),
    .top_valid_o(top_valid_o), .top_addr_o(top_addr_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  // reference stack: a ring of DEPTH slots, a top index and a live count
  int          m_mem[DEPTH];
  int          m_tos, m_cnt, c_tos, c_cnt;
  bit          m_ovf, m_udf;

  function automatic logic [RW-1:0] pack(input bit v, input logic [AW-1:0] a,
                                         input int c, input bit o, input bit u);
    return {v, a, (DL+1)'(c), o, u};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_tos = DEPTH - 1; m_cnt = 0; c_tos = 0; c_cnt = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_step(input bit pu, input logic [AW-1:0] a, input bit po,
                            input bit sv, input bit rs);
    m_ovf = 0; m_udf = 0;
    if (rs) begin
      m_tos = c_tos; m_cnt = c_cnt;
    end else begin
      if (pu && po && m_cnt > 0) m_mem[m_tos] = a;
      else if (pu) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = a;
        if (m_cnt == DEPTH) m_ovf = 1; else m_cnt = m_cnt + 1;
      end else if (po) begin
        if (m_cnt > 0) begin m_tos = (m_tos + DEPTH - 1) % DEPTH; m_cnt = m_cnt - 1; end
        else m_udf = 1;
      end
      if (sv) begin c_tos = m_tos; c_cnt = m_cnt; end
    end
  endtask

  function automatic logic [RW-1:0] model_out();
    return pack(m_cnt != 0, (m_cnt != 0) ? AW'(m_mem[m_tos]) : '0, m_cnt, m_ovf, m_udf);
  endfunction

  // driver: apply one cycle's request at the falling edge, predict, enqueue
  task automatic do_op(input bit pu, input logic [AW-1:0] a, input bit po,
                       input bit sv = 0, input bit rs = 0);
    @(negedge clk);
    push_i = pu; push_addr_i = a; pop_i = po; ckpt_save_i = sv; ckpt_restore_i = rs;
    model_step(pu, a, po, sv, rs);
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    push_i = 0; pop_i = 0; ckpt_save_i = 0; ckpt_restore_i = 0;
  endtask

  task automatic push(input logic [AW-1:0] a); do_op(1, a, 0); endtask
  task automatic pop();                         do_op(0, '0, 1); endtask

  task automatic check_now(input string name, input logic [RW-1:0] req);
    logic [RW-1:0] act;
    act = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // monitor: outputs are presented every cycle; compare against the oldest prediction
  always @(posedge clk) begin
    #1;
    if (rst && exp_q.size() > 0) begin
      logic [RW-1:0] e, act;
      e = exp_q.pop_front();
      act = {top_valid_o, top_addr_o, count_o, overflow_o, underflow_o};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t act(v,addr,cnt,ovf,udf)=%h exp=%h", $time, act, e);
      end
    end
  end

  initial begin
    rst = 0; push_i = 0; pop_i = 0; ckpt_save_i = 0; ckpt_restore_i = 0; push_addr_i = '0;
    model_reset();
    #20;
    check_now("reset_hold", pack(0, '0, 0, 0, 0));
    @(negedge clk); rst = 1;

    // async reset mid-cycle
    push(32'h2C);
    @(posedge clk); #3;
    rst = 0; #1;
    check_now("async_reset", pack(0, '0, 0, 0, 0));
    model_reset();
    @(negedge clk); rst = 1;

    // push/pop sequence
    push(32'h2C); push(32'h40); pop(); pop(); pop();

    // overflow and loss of the oldest entry
    push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
    pop(); pop(); pop(); pop(); pop();

    // simultaneous push+pop
    push(32'h2C); do_op(1, 32'h48, 1);
    pop(); do_op(1, 32'h48, 1);

    // checkpoint / restore
    pop(); push(32'h2C); do_op(0, '0, 0, 1, 0);
    push(32'h40); push(32'h44); do_op(0, '0, 0, 0, 1);
    do_op(1, 32'h99, 0, 0, 1);
    do_op(0, '0, 1, 0, 1);

    // program level: jal at 0x24 links 0x2C, jr $31 returns there
    pop();
    push(32'h24 + 32'd8);
    @(negedge clk);
    check_now("jal_link_31", pack(1, 32'h0000002C, 1, 0, 0));
    pop();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit pu, po, sv, rs;
      pu = ($urandom_range(0, 99) < 45);
      po = ($urandom_range(0, 99) < 40);
      sv = ($urandom_range(0, 99) < 10);
      rs = ($urandom_range(0, 99) < 6);
      do_op(pu, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, po, sv, rs);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d req=0 entries left", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
